// File: rtl/ksa_share_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : ksa_share_arb_if
// Brief    : Requester/consumer bundle for ksa_share_arb; res_ovf exists only
//            when KSA_SHARE_OVF_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface ksa_share_arb_if #(
    parameter int N  = 8,
    parameter int R  = 4,
    parameter int RW = $clog2(R)
);
    logic [R-1:0]   req_valid;
    logic [R-1:0]   req_last;
    logic [R*N-1:0] req_a;
    logic [R*N-1:0] req_b;
    logic [R-1:0]   req_cin;
    logic [R-1:0]   req_ready;
    logic           res_valid;
    logic           res_ready;
    logic [RW-1:0]  res_id;
    logic [N-1:0]   res_sum;
    logic           res_cout;
    logic           res_last;
`ifdef KSA_SHARE_OVF_EN
    logic           res_ovf;
`endif

    modport master (
`ifdef KSA_SHARE_OVF_EN
        input  res_ovf,
`endif
        output req_valid, req_last, req_a, req_b, req_cin, res_ready,
        input  req_ready, res_valid, res_id, res_sum, res_cout, res_last
    );

    modport slave (
`ifdef KSA_SHARE_OVF_EN
        output res_ovf,
`endif
        input  req_valid, req_last, req_a, req_b, req_cin, res_ready,
        output req_ready, res_valid, res_id, res_sum, res_cout, res_last
    );
endinterface
`default_nettype wire

// File: rtl/ksa_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : ksa_share_arb
// Brief    : Round-robin sequencer sharing one Kogge-Stone adder among R
//            word-serial requesters. Optional KSA_SHARE_OVF_EN adds res_ovf.
// Revision : 1.0 - initial release
// ============================================================================
module ksa_share_arb #(
    parameter int N  = 8,
    parameter int R  = 4,
    parameter int RW = $clog2(R)
) (
    input  logic             clk,
    input  logic             rst_n,
    ksa_share_arb_if.slave   bus
);
    localparam int       c_lv   = (N > 1) ? $clog2(N) : 1;
    localparam logic [0:0] c_idle = 1'b0;
    localparam logic [0:0] c_busy = 1'b1;

    logic [0:0]    r_state;
    logic [RW-1:0] r_grant;
    logic [RW-1:0] r_rr;
    logic          r_carry;
    logic          r_first;

    logic [N-1:0]  w_a, w_b, w_p;
    logic [N-1:0]  w_gk, w_pk, w_gn, w_pn;
    logic [N:0]    w_c;
    logic          w_cin;
    logic          w_accept, w_xfer, w_last;
    logic          w_found;
    logic [RW-1:0] w_pick;

    assign w_a    = bus.req_a[int'(r_grant) * N +: N];
    assign w_b    = bus.req_b[int'(r_grant) * N +: N];
    assign w_cin  = r_first ? bus.req_cin[r_grant] : r_carry;
    assign w_last = bus.req_last[r_grant];

    // A beat is accepted only when the output register is free or draining.
    assign w_accept = (r_state == c_busy) && (!bus.res_valid || bus.res_ready);
    assign w_xfer   = w_accept && bus.req_valid[r_grant];

    always_comb begin
        bus.req_ready = '0;
        if (w_accept) begin
            bus.req_ready[r_grant] = 1'b1;
        end
    end

    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = 0; k < R; k++) begin
            if (!w_found && bus.req_valid[(int'(r_rr) + k) % R]) begin
                w_found = 1'b1;
                w_pick  = RW'((int'(r_rr) + k) % R);
            end
        end
    end

    // Kogge-Stone: cin folded into bit-0 generate so every prefix G[i:0]
    // is directly the carry into bit i+1.
    always_comb begin
        w_p     = w_a ^ w_b;
        w_gk    = w_a & w_b;
        w_gk[0] = w_gk[0] | (w_p[0] & w_cin);
        w_pk    = w_p;
        w_gn    = '0;
        w_pn    = '0;
        for (int l = 0; l < c_lv; l++) begin
            w_gn = w_gk;
            w_pn = w_pk;
            for (int i = 0; i < N; i++) begin
                if (i >= (1 << l)) begin
                    w_gn[i] = w_gk[i] | (w_pk[i] & w_gk[(i >= (1 << l)) ? i - (1 << l) : i]);
                    w_pn[i] = w_pk[i] & w_pk[(i >= (1 << l)) ? i - (1 << l) : i];
                end
            end
            w_gk = w_gn;
            w_pk = w_pn;
        end
        w_c = {w_gk, w_cin};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= c_idle;
            r_grant       <= '0;
            r_rr          <= '0;
            r_carry       <= 1'b0;
            r_first       <= 1'b0;
            bus.res_valid <= 1'b0;
            bus.res_id    <= '0;
            bus.res_sum   <= '0;
            bus.res_cout  <= 1'b0;
            bus.res_last  <= 1'b0;
`ifdef KSA_SHARE_OVF_EN
            bus.res_ovf   <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_idle: begin
                    if (w_found) begin
                        r_grant <= w_pick;
                        r_first <= 1'b1;
                        r_state <= c_busy;
                    end
                end
                c_busy: begin
                    if (w_xfer) begin
                        r_carry <= w_c[N];
                        r_first <= 1'b0;
                        if (w_last) begin
                            r_state <= c_idle;
                            r_rr    <= (r_grant == RW'(R - 1)) ? '0 : r_grant + 1'b1;
                        end
                    end
                end
                default: r_state <= c_idle;
            endcase

            if (w_xfer) begin
                bus.res_valid <= 1'b1;
                bus.res_id    <= r_grant;
                bus.res_sum   <= w_p ^ w_c[N-1:0];
                bus.res_cout  <= w_c[N];
                bus.res_last  <= w_last;
`ifdef KSA_SHARE_OVF_EN
                bus.res_ovf   <= w_last & (w_c[N-1] ^ w_c[N]);
`endif
            end else if (bus.res_ready) begin
                bus.res_valid <= 1'b0;
            end
        end
    end
endmodule
`default_nettype wire

// File: doc/ksa_share_arb.md
Name: ksa_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one N-bit parallel-prefix (Kogge-Stone) adder datapath between R requesters.
- Each request is a word-serial multi-beat addition. Beats run LSW first, and the carry is chained across beats, so narrow adders can serve wide operands.
- Sits between requester ports and downstream result consumers. Result output is registered, with a valid/ready handshake on both sides.

Parameters:
- N, 8, adder word width in bits.
- R, 4, number of requesters (R >= 2).
- RW, $clog2(R), width of requester ID.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- req_valid  input  R  per-requester beat valid
- req_last  input  R  beat is final word of the transaction
- req_a  input  R*N  operand A, requester i at bits [i*N +: N]
- req_b  input  R*N  operand B, same packing as req_a
- req_cin  input  R  carry-in, sampled on the first beat of a transaction only
- req_ready  output  R  per-requester beat accept
- res_valid  output  1  result beat valid
- res_ready  input  1  consumer accepts result beat
- res_id  output  RW  requester that owns the result beat
- res_sum  output  N  sum word
- res_cout  output  1  carry-out of this word
- res_last  output  1  copy of req_last for this beat

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset values: all outputs 0. State IDLE, grant 0, RR pointer 0, carry register 0.
- A beat transfers when req_valid[i] && req_ready[i]. A result transfers when res_valid && res_ready.
- FSM states: IDLE, BUSY.
  - IDLE: req_ready = 0. If any req_valid is set, pick the first set bit searching from the RR pointer upward, with wrap-around. Register it as grant and go to BUSY. This costs one arbitration cycle per transaction.
  - BUSY: req_ready[grant] = (!res_valid || res_ready). All other req_ready bits are 0.
  - BUSY to IDLE: on the cycle the beat with req_last=1 transfers. RR pointer becomes (grant+1) mod R in the same cycle.
- Lock: grant is held until the last beat transfers, even if req_valid[grant] drops between beats. Other requesters wait.
- Carry: the first beat of a transaction uses req_cin[grant]. Later beats use the carry register, which is loaded with cout on every transferred beat.
- Arithmetic:
  - {cout, sum} = a + b + cin, computed as an N-bit prefix adder: generate/propagate pre-processing, log2(N) prefix levels, then sum XOR.
  - No truncation; cout is carry out of bit N-1.
- Latency: exactly 1 cycle from beat transfer to res_valid. res_* are registered in the transfer cycle.
- Holding: res_sum, res_cout, res_id and res_last are held stable while res_valid && !res_ready.
- Simultaneous events:
  - A result drain and a new beat accept in the same cycle are both allowed, giving full throughput of 1 beat/cycle within a transaction.
  - res_valid stays 1 in that case.
  - res_valid clears only when the result drains and no new beat transfers.
- Requests arriving while BUSY wait. A new requester raising req_valid does not preempt the current transaction.
- Single-beat transaction (req_last=1 on the first beat): legal, uses req_cin.
- Reset mid-operation: the in-flight transaction is abandoned. Any pending result is dropped (res_valid=0 the next cycle), the carry register is cleared and the RR pointer returns to 0.

Optional Feature:
- Macro: KSA_SHARE_OVF_EN.
- With the macro defined, add output port res_ovf (1 bit, registered alongside res_sum).
  - res_ovf = carry into bit N-1 XOR cout, i.e. signed overflow.
  - Valid only when res_last=1; forced to 0 on non-last beats and at reset.
- Without the macro, port res_ovf and its logic are absent and all other behaviour is identical.

Test Plan:
1. N=8: requester 0 sends a=0xFF, b=0x01, cin=0, last=1 -> one cycle after transfer res_valid=1 with sum=0x00, cout=1, id=0, last=1.
2. Requester 2 sends beat0 a=0xFF, b=0x01, cin=0, then beat1 a=0x00, b=0x00 with last=1 -> results 0x00/cout=1, then 0x01/cout=0. The chained carry is applied and req_cin is ignored on beat1.
3. After reset, all four requesters hold continuous single-beat requests -> grant order 0,1,2,3,0,1. Each transaction is preceded by one IDLE cycle with req_ready=0.
4. res_ready held low for 3 cycles during a 3-beat transaction -> res_* stable, req_ready[grant]=0, no beat lost or duplicated. After release, 1 beat/cycle is observed.
5. rst_n=0 for one cycle during beat 2 of a 3-beat transaction from requester 1 -> next cycle res_valid=0, all req_ready=0, state IDLE. A subsequent request from requester 3 with cin=1, a=0x10, b=0x20 gives sum=0x31.
6. KSA_SHARE_OVF_EN defined: a=0x7F, b=0x01, cin=0, last=1 -> sum=0x80, cout=0, res_ovf=1. Non-last beat with the same operands -> res_ovf=0.
